riscv_lsu: RTL

Load/store unit sitting directly downstream of `decoder_riscv` in the RISC-V core. It consumes the decoder's memory control (`mem_req_o`, `mem_we_o`, `mem_size_o`) together with the ALU-computed address and the rs2 data. It drives a word-addressed data-memory port with byte enables and a ready handshake. While an access is outstanding it stalls the core, and it returns sign- or zero-extended load data for the `WB_LSU_DATA` write-back path.

---
 rtl/riscv_lsu_pkg.sv | 31 +++
 rtl/riscv_lsu_align.sv | 74 +++++++
 rtl/riscv_lsu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared load/store definitions: access size encodings, LSU state codes and
// the alignment rule used by the request path.
package riscv_lsu_pkg;

    // Access size encodings as produced by the decoder on mem_size_o.
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // LSU state codes.
    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_WAIT = 2'd1;
    localparam logic [1:0] LSU_DONE = 2'd2;

    // True when the access cannot be served by a single word access.
    // Unused size codes fall into the word case.
    function automatic logic lsu_misaligned(input logic [2:0] size,
                                            input logic [1:0] off);
        logic mis;
        case (size)
            LDST_B, LDST_BU: mis = 1'b0;
            LDST_H, LDST_HU: mis = off[0];
            LDST_W:          mis = (off != 2'b00);
            default:         mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane alignment for the LSU: byte enables and replicated store data on the
// way out, byte/halfword extraction with sign or zero extension on the way in.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wd_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wd_o,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_rd_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store path: select lanes and replicate data across the word.
    always_comb begin
        st_be_o = 4'b1111;
        st_wd_o = st_wd_i;
        case (st_size_i)
            LDST_B, LDST_BU: begin
                st_be_o = 4'b0001 << st_off_i;
                st_wd_o = {4{st_wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                st_be_o = 4'b0011 << {st_off_i[1], 1'b0};
                st_wd_o = {2{st_wd_i[15:0]}};
            end
            LDST_W: begin
                st_be_o = 4'b1111;
                st_wd_o = st_wd_i;
            end
            default: begin
                st_be_o = 4'b1111;
                st_wd_o = st_wd_i;
            end
        endcase
    end

    // Load path: pick the addressed byte and halfword out of the word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (ld_off_i)
            2'd0:    byte_s = ld_word_i[7:0];
            2'd1:    byte_s = ld_word_i[15:8];
            2'd2:    byte_s = ld_word_i[23:16];
            default: byte_s = ld_word_i[31:24];
        endcase
        if (ld_off_i[1]) begin
            half_s = ld_word_i[31:16];
        end else begin
            half_s = ld_word_i[15:0];
        end
    end

    // Load path: extend the selected lane to 32 bits.
    always_comb begin
        ld_rd_o = ld_word_i;
        case (ld_size_i)
            LDST_B:  ld_rd_o = {{24{byte_s[7]}}, byte_s};
            LDST_BU: ld_rd_o = {24'h000000, byte_s};
            LDST_H:  ld_rd_o = {{16{half_s[15]}}, half_s};
            LDST_HU: ld_rd_o = {16'h0000, half_s};
            LDST_W:  ld_rd_o = ld_word_i;
            default: ld_rd_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding access at a time, stalls the core until
// the memory answers, then presents extended load data for one DONE cycle.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wd_i,
    output logic [31:0]       lsu_rd_o,
    output logic              lsu_stall_o,
    output logic              lsu_misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i,
    input  logic              mem_ready_i
);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic [31:0]       load_q, load_d;

    logic              misalign_s;
    logic              accept_s;
    logic              mem_req_s;
    logic              cur_we_s;
    logic [2:0]        cur_size_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [31:0]       cur_wd_s;
    logic [3:0]        al_be_s;
    logic [31:0]       al_wd_s;
    logic [31:0]       al_rd_s;

    assign misalign_s = lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);
    assign accept_s   = (state_q == LSU_IDLE) && lsu_req_i && !misalign_s;
    assign mem_req_s  = accept_s || (state_q == LSU_WAIT);

    // Request source: live inputs in the accept cycle, latched copy while waiting
    // so the memory port stays stable even if the core's operands move.
    always_comb begin
        if (state_q == LSU_WAIT) begin
            cur_we_s   = we_q;
            cur_size_s = size_q;
            cur_addr_s = addr_q;
            cur_wd_s   = wd_q;
        end else begin
            cur_we_s   = lsu_we_i;
            cur_size_s = lsu_size_i;
            cur_addr_s = lsu_addr_i;
            cur_wd_s   = lsu_wd_i;
        end
    end

    riscv_lsu_align u_align (
        .st_size_i (cur_size_s),
        .st_off_i  (cur_addr_s[1:0]),
        .st_wd_i   (cur_wd_s),
        .st_be_o   (al_be_s),
        .st_wd_o   (al_wd_s),
        .ld_size_i (size_q),
        .ld_off_i  (addr_q[1:0]),
        .ld_word_i (load_q),
        .ld_rd_o   (al_rd_s)
    );

    // Core and memory side outputs; everything on the memory port is zero when idle.
    always_comb begin
        lsu_stall_o    = mem_req_s;
        lsu_misalign_o = (state_q == LSU_IDLE) && lsu_req_i && misalign_s;
        mem_req_o      = mem_req_s;
        if (mem_req_s) begin
            mem_we_o   = cur_we_s;
            mem_be_o   = al_be_s;
            mem_addr_o = {cur_addr_s[ADDR_W-1:2], 2'b00};
            mem_wd_o   = al_wd_s;
        end else begin
            mem_we_o   = 1'b0;
            mem_be_o   = 4'b0000;
            mem_addr_o = {ADDR_W{1'b0}};
            mem_wd_o   = 32'h00000000;
        end
        if (state_q == LSU_DONE) begin
            lsu_rd_o = al_rd_s;
        end else begin
            lsu_rd_o = 32'h00000000;
        end
    end

    // Next-state logic: latch the request on accept, capture load data on ready.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        load_d  = load_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept_s) begin
                    we_d   = lsu_we_i;
                    size_d = lsu_size_i;
                    addr_d = lsu_addr_i;
                    wd_d   = lsu_wd_i;
                    if (mem_ready_i) begin
                        state_d = LSU_DONE;
                        if (!lsu_we_i) begin
                            load_d = mem_rd_i;
                        end else begin
                            load_d = load_q;
                        end
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_WAIT: begin
                if (mem_ready_i) begin
                    state_d = LSU_DONE;
                    if (!we_q) begin
                        load_d = mem_rd_i;
                    end else begin
                        load_d = load_q;
                    end
                end else begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= {ADDR_W{1'b0}};
            wd_q    <= 32'h00000000;
            load_q  <= 32'h00000000;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            load_q  <= load_d;
        end
    end

endmodule
